// File: rtl/mmio_display_ctrl_pkg.sv
// Shared address defaults, ctrl field positions and the hex-to-segment encoder
// used by mmio_display_ctrl.
package mmio_display_pkg;

   localparam int DEF_BTN_ADDR   = 0;
   localparam int DEF_DISP_ADDR  = 1;
   localparam int DEF_CTRL_ADDR  = 3;

   localparam int CTRL_BLANK_LSB = 0;
   localparam int CTRL_DP_LSB    = 8;

   // Active-high segments, bit order g..a.
   function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'h0:    s = 7'h3F;
         4'h1:    s = 7'h06;
         4'h2:    s = 7'h5B;
         4'h3:    s = 7'h4F;
         4'h4:    s = 7'h66;
         4'h5:    s = 7'h6D;
         4'h6:    s = 7'h7D;
         4'h7:    s = 7'h07;
         4'h8:    s = 7'h7F;
         4'h9:    s = 7'h6F;
         4'hA:    s = 7'h77;
         4'hB:    s = 7'h7C;
         4'hC:    s = 7'h39;
         4'hD:    s = 7'h5E;
         4'hE:    s = 7'h79;
         default: s = 7'h71;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/mmio_display_ctrl_btn_debounce.sv
// One push-button channel: two-flop synchroniser followed by a run-length
// debouncer that flips the level after DEBOUNCE_CYC consecutive differing samples.
module btn_debounce #(
   parameter int DEBOUNCE_CYC = 500000
) (
   input  logic clk,
   input  logic res,
   input  logic btn_i,
   output logic level_o
);

   localparam int CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

   logic             sync1_q, sync2_q;
   logic             level_q, level_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d   = '0;
      level_d = level_q;
      if (sync2_q != level_q) begin
         if (cnt_q == CNT_LAST) begin
            level_d = ~level_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (res) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         level_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= btn_i;
         sync2_q <= sync1_q;
         level_q <= level_d;
         cnt_q   <= cnt_d;
      end
   end

   assign level_o = level_q;

endmodule

// File: rtl/mmio_display_ctrl.sv
// Memory-mapped seven-segment scan controller with debounced buttons.
// Optional sticky rising-edge flags on the button register: MMIO_DISPLAY_CTRL_BTN_EDGE_EN.
module mmio_display_ctrl
   import mmio_display_pkg::*;
#(
   parameter int ADDR_W       = 12,
   parameter int DATA_W       = 16,
   parameter int DIGITS       = 4,
   parameter int NUM_BTN      = 2,
   parameter int BTN_ADDR     = DEF_BTN_ADDR,
   parameter int DISP_ADDR    = DEF_DISP_ADDR,
   parameter int CTRL_ADDR    = DEF_CTRL_ADDR,
   parameter int REFRESH_DIV  = 50000,
   parameter int DEBOUNCE_CYC = 500000
) (
   input  logic              clk,
   input  logic              res,
   input  logic              bus_sel,
   input  logic              bus_ld,
   input  logic [ADDR_W-1:0] bus_addr,
   input  logic [DATA_W-1:0] bus_wdata,
   output logic [DATA_W-1:0] bus_rdata,
   output logic              bus_hit,
   input  logic [NUM_BTN-1:0] btn,
   output logic [DIGITS-1:0] dig,
   output logic [7:0]        seg
);

   localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int DIV_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int DISP_W = (DIGITS > 4) ? 32 : 16;
   localparam int SHD_W  = 4 * DIGITS;

   logic hit_btn, hit_lo, hit_hi, hit_ctrl, wr_en, rd_en;

   assign hit_btn  = (bus_addr == ADDR_W'(BTN_ADDR));
   assign hit_lo   = (bus_addr == ADDR_W'(DISP_ADDR));
   assign hit_hi   = (DIGITS > 4) && (bus_addr == ADDR_W'(DISP_ADDR + 1));
   assign hit_ctrl = (bus_addr == ADDR_W'(CTRL_ADDR));
   assign bus_hit  = bus_sel & (hit_btn | hit_lo | hit_hi | hit_ctrl);
   assign wr_en    = bus_hit & ~bus_ld;
   assign rd_en    = bus_hit & bus_ld;

   logic [NUM_BTN-1:0] btn_lvl;

   generate
      for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
         btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb (
            .clk     (clk),
            .res     (res),
            .btn_i   (btn[gi]),
            .level_o (btn_lvl[gi])
         );
      end
   endgenerate

`ifdef MMIO_DISPLAY_CTRL_BTN_EDGE_EN
   logic [NUM_BTN-1:0] lvl_prev_q, edge_q, edge_d;

   // A new rising edge outranks a simultaneous read-clear.
   always_comb begin
      edge_d = edge_q;
      if (rd_en && hit_btn) begin
         edge_d = '0;
      end
      edge_d = edge_d | (btn_lvl & ~lvl_prev_q);
   end

   always_ff @(posedge clk) begin
      if (res) begin
         lvl_prev_q <= '0;
         edge_q     <= '0;
      end else begin
         lvl_prev_q <= btn_lvl;
         edge_q     <= edge_d;
      end
   end
`endif

   logic [DISP_W-1:0] disp_q, disp_d;
   logic [15:0]       ctrl_q, ctrl_d;
   logic [15:0]       btn_word, rdata_q, rdata_d;

   always_comb begin
      disp_d = disp_q;
      ctrl_d = ctrl_q;
      if (wr_en) begin
         if (hit_lo)   disp_d[15:0] = bus_wdata;
         if (hit_hi)   disp_d[DISP_W-1 -: 16] = bus_wdata;
         if (hit_ctrl) ctrl_d = bus_wdata;
      end
   end

   always_comb begin
      btn_word = '0;
      btn_word[NUM_BTN-1:0] = btn_lvl;
`ifdef MMIO_DISPLAY_CTRL_BTN_EDGE_EN
      btn_word[8 +: NUM_BTN] = edge_q;
`else
      btn_word[15:8] = '0;
`endif
      rdata_d = '0;
      if (rd_en) begin
         if (hit_btn)       rdata_d = btn_word;
         else if (hit_lo)   rdata_d = disp_q[15:0];
         else if (hit_hi)   rdata_d = disp_q[DISP_W-1 -: 16];
         else if (hit_ctrl) rdata_d = ctrl_q;
      end
   end

   logic [DIV_W-1:0]  div_q, div_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [SHD_W-1:0]  shd_disp_q, shd_disp_d;
   logic [DIGITS-1:0] shd_blank_q, shd_blank_d, shd_dp_q, shd_dp_d;
   logic [DIGITS-1:0] dig_q, dig_d, onehot;
   logic [7:0]        seg_q, seg_d;
   logic [3:0]        nib;
   logic              blank_bit, dp_bit, tick, frame_start;

   assign tick        = (div_q == DIV_W'(REFRESH_DIV - 1));
   assign frame_start = tick && (idx_q == '0);

   // Digit 0 is lit from the shadow value being captured on the same edge.
   always_comb begin
      div_d = tick ? '0 : div_q + 1'b1;
      idx_d = idx_q;
      if (tick) begin
         idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
      end
      shd_disp_d  = shd_disp_q;
      shd_blank_d = shd_blank_q;
      shd_dp_d    = shd_dp_q;
      if (frame_start) begin
         shd_disp_d  = disp_q[SHD_W-1:0];
         shd_blank_d = ctrl_q[CTRL_BLANK_LSB +: DIGITS];
         shd_dp_d    = ctrl_q[CTRL_DP_LSB +: DIGITS];
      end
      nib       = '0;
      blank_bit = 1'b0;
      dp_bit    = 1'b0;
      onehot    = '0;
      for (int i = 0; i < DIGITS; i++) begin
         if (idx_q == IDX_W'(i)) begin
            nib       = shd_disp_d[4*i +: 4];
            blank_bit = shd_blank_d[i];
            dp_bit    = shd_dp_d[i];
            onehot[i] = 1'b1;
         end
      end
      dig_d = dig_q;
      seg_d = seg_q;
      if (tick) begin
         if (blank_bit) begin
            dig_d = '1;
            seg_d = 8'hFF;
         end else begin
            dig_d = ~onehot;
            seg_d = {~dp_bit, ~hex_to_seg(nib)};
         end
      end
   end

   always_ff @(posedge clk) begin
      if (res) begin
         disp_q      <= '0;
         ctrl_q      <= '0;
         rdata_q     <= '0;
         div_q       <= '0;
         idx_q       <= '0;
         shd_disp_q  <= '0;
         shd_blank_q <= '0;
         shd_dp_q    <= '0;
         dig_q       <= '1;
         seg_q       <= 8'hFF;
      end else begin
         disp_q      <= disp_d;
         ctrl_q      <= ctrl_d;
         rdata_q     <= rdata_d;
         div_q       <= div_d;
         idx_q       <= idx_d;
         shd_disp_q  <= shd_disp_d;
         shd_blank_q <= shd_blank_d;
         shd_dp_q    <= shd_dp_d;
         dig_q       <= dig_d;
         seg_q       <= seg_d;
      end
   end

   assign bus_rdata = rdata_q;
   assign dig       = dig_q;
   assign seg       = seg_q;

endmodule
